// File: rtl/fetch_stage_if.sv
// Bundles the program-memory port and the fetch/execute handshake of fetch_stage.
// master = the fetch stage itself, slave = its surroundings (memory + execute stage).
interface fetch_stage_if;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic [7:0] mem_rdata;
  logic       StageComplete;
  logic [7:0] NextPctr;
  logic       irq;
  logic [7:0] InteruptAdrReg;
  logic [4:0] StageRegInstr_out;
  logic [2:0] StageRegAddrMode_out;
  logic [7:0] StageRegData_out;
  logic [7:0] StageRegPCtr_out;
  logic       StageValid;
  logic       irq_ack;

  modport master (
    output mem_addr, mem_rd,
    input  mem_rdata,
    input  StageComplete, NextPctr, irq, InteruptAdrReg,
    output StageRegInstr_out, StageRegAddrMode_out, StageRegData_out, StageRegPCtr_out,
    output StageValid, irq_ack
  );

  modport slave (
    input  mem_addr, mem_rd,
    output mem_rdata,
    output StageComplete, NextPctr, irq, InteruptAdrReg,
    input  StageRegInstr_out, StageRegAddrMode_out, StageRegData_out, StageRegPCtr_out,
    input  StageValid, irq_ack
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch / stage register ahead of the accumulator execute stage.
// Fetches 1- or 2-byte instructions, holds them until StageComplete, then redirects the PC.
module fetch_stage #(
  parameter logic [7:0] RESET_PC      = 8'h00,
  parameter logic [2:0] INHERENT_MODE = 3'b000
) (
  input logic          clk,
  input logic          reset,
  fetch_stage_if.master bus
);

  localparam logic [2:0] S_OPC   = 3'd0;
  localparam logic [2:0] S_OPC_W = 3'd1;
  localparam logic [2:0] S_OPR   = 3'd2;
  localparam logic [2:0] S_OPR_W = 3'd3;
  localparam logic [2:0] S_ISSUE = 3'd4;

  logic [2:0] state_reg, state_next;
  logic [7:0] pc_reg, pc_next;
  logic [7:0] addr_reg, addr_next;
  logic       irq_pending_reg, irq_pending_next;
  logic       irq_ack_reg, irq_ack_next;
  logic       valid_reg, valid_next;
  logic [4:0] instr_reg, instr_next;
  logic [2:0] mode_reg, mode_next;
  logic [7:0] data_reg, data_next;
  logic [7:0] pctr_reg, pctr_next;

  logic       complete;
  logic       take_irq;
  logic [7:0] redirect_pc;

  // An irq arriving in the very cycle of StageComplete is already taken at that edge.
  assign complete    = (state_reg == S_ISSUE) && bus.StageComplete;
  assign take_irq    = complete && (irq_pending_reg || bus.irq);
  assign redirect_pc = take_irq ? bus.InteruptAdrReg : bus.NextPctr;

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    addr_next        = addr_reg;
    valid_next       = valid_reg;
    instr_next       = instr_reg;
    mode_next        = mode_reg;
    data_next        = data_reg;
    pctr_next        = pctr_reg;
    irq_ack_next     = take_irq;
    irq_pending_next = take_irq ? 1'b0 : (irq_pending_reg | bus.irq);

    case (state_reg)
      S_OPC: state_next = S_OPC_W;
      S_OPC_W: begin
        instr_next = bus.mem_rdata[7:3];
        mode_next  = bus.mem_rdata[2:0];
        pctr_next  = pc_reg;
        if (bus.mem_rdata[2:0] == INHERENT_MODE) begin
          data_next  = 8'h00;
          valid_next = 1'b1;
          state_next = S_ISSUE;
        end else begin
          addr_next  = pc_reg + 8'd1;
          state_next = S_OPR;
        end
      end
      S_OPR: state_next = S_OPR_W;
      S_OPR_W: begin
        data_next  = bus.mem_rdata;
        valid_next = 1'b1;
        state_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (complete) begin
          pc_next    = redirect_pc;
          addr_next  = redirect_pc;
          valid_next = 1'b0;
          state_next = S_OPC;
        end
      end
      default: state_next = S_OPC;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= S_OPC;
      pc_reg          <= RESET_PC;
      addr_reg        <= RESET_PC;
      irq_pending_reg <= 1'b0;
      irq_ack_reg     <= 1'b0;
      valid_reg       <= 1'b0;
      instr_reg       <= 5'd0;
      mode_reg        <= 3'd0;
      data_reg        <= 8'h00;
      pctr_reg        <= 8'h00;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      addr_reg        <= addr_next;
      irq_pending_reg <= irq_pending_next;
      irq_ack_reg     <= irq_ack_next;
      valid_reg       <= valid_next;
      instr_reg       <= instr_next;
      mode_reg        <= mode_next;
      data_reg        <= data_next;
      pctr_reg        <= pctr_next;
    end
  end

  // Read strobe is decoded from state; gated so it reads 0 while reset is held.
  assign bus.mem_rd               = ~reset && ((state_reg == S_OPC) || (state_reg == S_OPR));
  assign bus.mem_addr             = addr_reg;
  assign bus.StageValid           = valid_reg;
  assign bus.irq_ack              = irq_ack_reg;
  assign bus.StageRegInstr_out    = instr_reg;
  assign bus.StageRegAddrMode_out = mode_reg;
  assign bus.StageRegData_out     = data_reg;
  assign bus.StageRegPCtr_out     = pctr_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised scoreboard bench for fetch_stage: the driver pushes expected instructions
// and irq_ack cycles; an independent monitor pops and compares on DUT activity.
module tb_fetch_stage;

  typedef struct {
    logic [4:0] instr;
    logic [2:0] mode;
    logic [7:0] data;
    logic [7:0] pctr;
    int         exp_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(8'h00), .INHERENT_MODE(3'b000)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  logic [7:0] mem [256];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   ack_q[$];
  bit   irq_seen = 1'b0;

  always @(posedge clk) cyc++;
  always @(posedge clk) if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference: the instruction at pc is its opcode byte plus, unless inherent, the next byte.
  task automatic push_exp(input logic [7:0] pc, input int base_lat);
    exp_t       e;
    logic [7:0] op;
    logic [7:0] pc1;
    bit         inh;
    op  = mem[pc];
    pc1 = pc + 8'd1;
    inh = (op[2:0] == 3'b000);
    e.instr   = op[7:3];
    e.mode    = op[2:0];
    e.data    = inh ? 8'h00 : mem[pc1];
    e.pctr    = pc;
    e.exp_cyc = cyc + base_lat + (inh ? 0 : 2);
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  exp_t cur;
  bit   prev_valid = 1'b0;
  int   rd_phase = 0;

  always @(negedge clk) begin
    logic [7:0] want_addr;
    if (reset) begin
      prev_valid = 1'b0;
      rd_phase   = 0;
    end else begin
      if (bus.mem_rd) begin
        if (exp_q.size() == 0) fail("unexpected_read");
        else begin
          want_addr = exp_q[0].pctr + 8'(rd_phase);
          chk((rd_phase == 0) ? "fetch_addr" : "operand_addr", bus.mem_addr, want_addr);
        end
        rd_phase++;
      end
      if (bus.StageValid && !prev_valid) begin
        if (exp_q.size() == 0) fail("unexpected_issue");
        else begin
          cur = exp_q.pop_front();
          chk("instr",   bus.StageRegInstr_out,    cur.instr);
          chk("mode",    bus.StageRegAddrMode_out, cur.mode);
          chk("data",    bus.StageRegData_out,     cur.data);
          chk("pctr",    bus.StageRegPCtr_out,     cur.pctr);
          chk("latency", cyc,                      cur.exp_cyc);
        end
        rd_phase = 0;
      end else if (bus.StageValid) begin
        chk("hold_instr", bus.StageRegInstr_out, cur.instr);
        chk("hold_data",  bus.StageRegData_out,  cur.data);
        chk("hold_pctr",  bus.StageRegPCtr_out,  cur.pctr);
        chk("issue_no_rd", bus.mem_rd, 1'b0);
      end
      if (bus.irq_ack) begin
        if (ack_q.size() == 0) fail("unexpected_irq_ack");
        else chk("irq_ack_cycle", cyc, ack_q.pop_front());
      end
      prev_valid = bus.StageValid;
    end
  end

  // ---------------- driver ----------------
  task automatic wait_issue();
    int n = 0;
    while (!bus.StageValid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.StageValid) fail("issue_timeout");
  endtask

  task automatic complete(input logic [7:0] next, input bit irq_now);
    bit taken;
    wait_issue();
    repeat ($urandom_range(0, 3)) @(negedge clk);
    bus.StageComplete = 1'b1;
    bus.NextPctr      = next;
    bus.irq           = irq_now;
    taken = irq_seen || irq_now;
    push_exp(taken ? bus.InteruptAdrReg : next, 3);
    if (taken) ack_q.push_back(cyc + 1);
    irq_seen = 1'b0;
    @(negedge clk);
    bus.StageComplete = 1'b0;
    bus.irq           = 1'b0;
    bus.NextPctr      = 8'($urandom);
  endtask

  // Mid-fetch noise: irq pulses become pending, stray StageComplete must be ignored.
  task automatic disturb();
    if ($urandom_range(0, 3) == 0) begin
      bus.irq  = 1'b1;
      irq_seen = 1'b1;
    end
    if ($urandom_range(0, 3) == 0) begin
      bus.StageComplete = 1'b1;
      bus.NextPctr      = 8'($urandom);
    end
    @(negedge clk);
    bus.irq           = 1'b0;
    bus.StageComplete = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h00] = 8'h28;
    mem[8'h10] = 8'h4B;
    mem[8'h11] = 8'h7F;
    mem[8'hFF] = 8'h93;
    mem[8'h55] = 8'h3A;
    bus.StageComplete  = 1'b0;
    bus.NextPctr       = 8'h00;
    bus.irq            = 1'b0;
    bus.InteruptAdrReg = 8'hE0;

    repeat (3) @(negedge clk);
    chk("rst_valid", bus.StageValid, 1'b0);
    chk("rst_rd",    bus.mem_rd,     1'b0);
    chk("rst_addr",  bus.mem_addr,   8'h00);
    chk("rst_instr", bus.StageRegInstr_out, 5'd0);
    chk("rst_ack",   bus.irq_ack,    1'b0);
    push_exp(8'h00, 2);
    reset = 1'b0;

    complete(8'h10, 1'b0);
    wait_issue();
    repeat (20) @(negedge clk);
    complete(8'h40, 1'b0);
    complete(8'hFF, 1'b0);
    bus.irq  = 1'b1;
    irq_seen = 1'b1;
    @(negedge clk);
    bus.irq = 1'b0;
    complete(8'h30, 1'b0);
    complete(8'h30, 1'b0);

    for (int it = 0; it < 150; it++) begin
      bus.InteruptAdrReg = 8'($urandom);
      complete(8'($urandom), ($urandom_range(0, 7) == 0));
      disturb();
    end

    // Reset while the operand read of the instruction at 0x55 is outstanding.
    complete(8'h55, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_valid", bus.StageValid, 1'b0);
    chk("midrst_addr",  bus.mem_addr,   8'h00);
    chk("midrst_rd",    bus.mem_rd,     1'b0);
    chk("midrst_pctr",  bus.StageRegPCtr_out, 8'h00);
    exp_q.delete();
    ack_q.delete();
    irq_seen = 1'b0;
    repeat (2) @(negedge clk);
    push_exp(8'h00, 2);
    reset = 1'b0;
    wait_issue();
    repeat (3) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("ack_q_drained", ack_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
